// File: rtl/aes_decrypt_ctrl.sv
// Sequencing controller for an iterative AES decryption datapath: one load,
// NROUNDS-1 shared inverse rounds, one final round, then a held result.
module aes_decrypt_ctrl #(
    parameter int NROUNDS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic       ld_en,
    output logic       round_en,
    output logic       final_en,
    output logic [3:0] rc,
    output logic       busy,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, HOLD} state_t;

    localparam logic [3:0] RC_START = 4'(NROUNDS - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        in_ready  = 1'b0;
        ld_en     = 1'b0;
        round_en  = 1'b0;
        final_en  = 1'b0;
        rc        = 4'd0;
        busy      = 1'b1;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = 1'b1;
                cnt_nx   = 4'd0;
                // ld_en is combinational on in_valid, so gate it while reset is held
                if (in_valid && !rst) begin
                    ld_en    = 1'b1;
                    state_nx = ROUND;
                    cnt_nx   = RC_START;
                end
            end
            ROUND: begin
                round_en = 1'b1;
                rc       = cnt;
                if (abort) begin
                    state_nx = IDLE;
                    cnt_nx   = 4'd0;
                end else if (cnt <= 4'd1) begin
                    // <= rather than == keeps a corrupted zero count from wrapping
                    state_nx = FINAL;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            FINAL: begin
                final_en = 1'b1;
                cnt_nx   = 4'd0;
                state_nx = abort ? IDLE : HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                cnt_nx    = 4'd0;
                if (abort || out_ready) state_nx = IDLE;
            end
            default: begin
                busy     = 1'b0;
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Directed bench for aes_decrypt_ctrl with a behavioural AES-128 inverse datapath
// driven by the controller's enables.
module tb_aes_decrypt_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic in_ready, ld_en, round_en, final_en, busy, out_valid;
    logic [3:0] rc;
    logic in_valid2 = 1'b0, abort2 = 1'b0, out_ready2 = 1'b1;
    logic in_ready2, ld_en2, round_en2, final_en2, busy2, out_valid2;
    logic [3:0] rc2;

    int total = 0;
    int bad = 0;

    logic [127:0] ct, key;
    localparam logic [127:0] CT_V  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_V = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_V  = 128'h00112233445566778899aabbccddeeff;

    aes_decrypt_ctrl #(.NROUNDS(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .abort(abort),
        .ld_en(ld_en), .round_en(round_en), .final_en(final_en), .rc(rc), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    aes_decrypt_ctrl #(.NROUNDS(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .abort(abort2),
        .ld_en(ld_en2), .round_en(round_en2), .final_en(final_en2), .rc(rc2), .busy(busy2),
        .out_valid(out_valid2), .out_ready(out_ready2)
    );

    always #5 clk = ~clk;

    wire [9:0] o  = {in_ready, busy, ld_en, round_en, final_en, out_valid, rc};
    wire [9:0] o2 = {in_ready2, busy2, ld_en2, round_en2, final_en2, out_valid2, rc2};

    function automatic logic [9:0] e_idle(input logic ld);
        return {1'b1, 1'b0, ld, 1'b0, 1'b0, 1'b0, 4'd0};
    endfunction
    function automatic logic [9:0] e_rnd(input logic [3:0] r);
        return {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, r};
    endfunction
    localparam logic [9:0] E_FIN  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
    localparam logic [9:0] E_HOLD = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #2;
    endtask

    // ---------------- behavioural AES-128 inverse datapath ----------------
    logic [7:0]  sb [256];
    logic [7:0]  isb[256];
    logic [7:0]  st [16];
    logic [31:0] kw [4];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction
    function automatic logic [7:0] rl(input logic [7:0] b);
        return {b[6:0], b[7]};
    endfunction
    function automatic logic [7:0] rcon(input int r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < r; i++) v = xt(v);
        return v;
    endfunction
    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction
    function automatic logic [31:0] rotw(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction
    function automatic logic [127:0] pt();
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[127-8*i -: 8] = st[i];
        return v;
    endfunction

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rl(inv) ^ rl(rl(inv)) ^ rl(rl(rl(inv))) ^ rl(rl(rl(rl(inv)))) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    end

    // The model starts from the last round key, derived here from the cipher key.
    task automatic dp_load(input logic [127:0] c, input logic [127:0] k);
        logic [31:0] w[44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subw(rotw(t)) ^ {rcon(i / 4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 4; i++) kw[i] = w[40+i];
        for (int i = 0; i < 16; i++) st[i] = c[127-8*i -: 8] ^ kw[i/4][31-8*(i%4) -: 8];
    endtask

    task automatic dp_round(input logic [3:0] r4, input logic mix);
        logic [31:0] a[4], b[4];
        logic [7:0]  t[16];
        logic [7:0]  a0, a1, a2, a3;
        a = kw;
        b[3] = a[3] ^ a[2];
        b[2] = a[2] ^ a[1];
        b[1] = a[1] ^ a[0];
        b[0] = a[0] ^ subw(rotw(b[3])) ^ {rcon(int'(r4) + 1), 24'h0};
        kw = b;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r+4*c] = isb[st[r+4*((c-r+4)%4)]];
        for (int i = 0; i < 16; i++) t[i] ^= kw[i/4][31-8*(i%4) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (mix) begin
                st[4*c]   = gm(a0,8'h0e)^gm(a1,8'h0b)^gm(a2,8'h0d)^gm(a3,8'h09);
                st[4*c+1] = gm(a0,8'h09)^gm(a1,8'h0e)^gm(a2,8'h0b)^gm(a3,8'h0d);
                st[4*c+2] = gm(a0,8'h0d)^gm(a1,8'h09)^gm(a2,8'h0e)^gm(a3,8'h0b);
                st[4*c+3] = gm(a0,8'h0b)^gm(a1,8'h0d)^gm(a2,8'h09)^gm(a3,8'h0e);
            end else begin
                st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
            end
        end
    endtask

    // Enables are stable mid-cycle; apply them on the falling edge.
    always @(negedge clk) begin
        if (ld_en)         dp_load(ct, key);
        else if (round_en) dp_round(rc, 1'b1);
        else if (final_en) dp_round(rc, 1'b0);
    end

    // ---------------- directed sequence ----------------
    initial begin
        ct  = CT_V;
        key = KEY_V;
        in_valid = 1'b1;
        #1 rst = 1'b1;
        #1 chk("rst_ld_gated", 128'(o), 128'(e_idle(1'b0)));
        nxt;
        chk("rst_held", 128'(o), 128'(e_idle(1'b0)));
        rst = 1'b0;
        in_valid = 1'b0;
        #1 chk("idle_after_rst", 128'(o), 128'(e_idle(1'b0)));

        nxt; abort = 1'b1;
        #1 chk("abort_idle_ignored", 128'(o), 128'(e_idle(1'b0)));
        nxt; abort = 1'b0;
        #1 chk("still_idle", 128'(o), 128'(e_idle(1'b0)));

        // Accept with abort asserted simultaneously, out_ready high
        nxt; in_valid = 1'b1; abort = 1'b1;
        #1 chk("acc_with_abort", 128'(o), 128'(e_idle(1'b1)));
        for (int i = 9; i >= 1; i--) begin
            nxt; in_valid = 1'b0; abort = 1'b0;
            #1 chk($sformatf("rnd_rc%0d", i), 128'(o), 128'(e_rnd(4'(i))));
        end
        nxt; #1 chk("final", 128'(o), 128'(E_FIN));
        nxt; #1 chk("hold", 128'(o), 128'(E_HOLD));
        chk("plaintext", pt(), PT_V);
        nxt; #1 chk("idle_T12", 128'(o), 128'(e_idle(1'b0)));

        // Back-pressured result; in_valid stays high throughout
        nxt; in_valid = 1'b1; out_ready = 1'b0;
        #1 chk("acc2", 128'(o), 128'(e_idle(1'b1)));
        for (int i = 9; i >= 1; i--) begin
            nxt; #1 chk($sformatf("rnd2_rc%0d", i), 128'(o), 128'(e_rnd(4'(i))));
        end
        nxt; #1 chk("final2", 128'(o), 128'(E_FIN));
        for (int i = 0; i < 5; i++) begin
            nxt; #1 chk($sformatf("hold_stall%0d", i), 128'(o), 128'(E_HOLD));
        end
        chk("plaintext_stall", pt(), PT_V);
        nxt; out_ready = 1'b1;
        #1 chk("hold_handshake_no_acc", 128'(o), 128'(E_HOLD));
        nxt; #1 chk("b2b_accept", 128'(o), 128'(e_idle(1'b1)));

        // Abort at T+4 of this block, then a fresh block at T+5
        for (int i = 9; i >= 7; i--) begin
            nxt; in_valid = 1'b0;
            #1 chk($sformatf("rnd3_rc%0d", i), 128'(o), 128'(e_rnd(4'(i))));
        end
        nxt; abort = 1'b1;
        #1 chk("abort_cycle_rc6", 128'(o), 128'(e_rnd(4'd6)));
        nxt; abort = 1'b0; in_valid = 1'b1;
        #1 chk("abort_to_idle_acc", 128'(o), 128'(e_idle(1'b1)));
        for (int i = 9; i >= 1; i--) begin
            nxt; in_valid = 1'b0;
            #1 chk($sformatf("rnd4_rc%0d", i), 128'(o), 128'(e_rnd(4'(i))));
        end
        nxt; #1 chk("final4", 128'(o), 128'(E_FIN));
        nxt; #1 chk("hold4", 128'(o), 128'(E_HOLD));
        chk("plaintext_after_abort", pt(), PT_V);
        nxt; #1 chk("idle4", 128'(o), 128'(e_idle(1'b0)));

        // Abort during FINAL skips HOLD
        nxt; in_valid = 1'b1;
        #1 chk("acc5", 128'(o), 128'(e_idle(1'b1)));
        for (int i = 9; i >= 1; i--) begin
            nxt; in_valid = 1'b0;
        end
        nxt; abort = 1'b1;
        #1 chk("final5_abort", 128'(o), 128'(E_FIN));
        nxt; abort = 1'b0;
        #1 chk("final_abort_idle", 128'(o), 128'(e_idle(1'b0)));

        // Asynchronous reset mid-ROUND at rc=6
        nxt; in_valid = 1'b1;
        #1 chk("acc6", 128'(o), 128'(e_idle(1'b1)));
        for (int i = 9; i >= 7; i--) begin
            nxt; in_valid = 1'b0;
        end
        nxt; #1 chk("rnd6_rc6", 128'(o), 128'(e_rnd(4'd6)));
        in_valid = 1'b1;
        rst = 1'b1;
        #1 chk("async_rst_outputs", 128'(o), 128'(e_idle(1'b0)));
        nxt; rst = 1'b0; in_valid = 1'b0;
        #1 chk("post_rst_idle", 128'(o), 128'(e_idle(1'b0)));
        for (int i = 0; i < 12; i++) begin
            nxt; #1 chk($sformatf("post_rst_quiet%0d", i), 128'(o), 128'(e_idle(1'b0)));
        end

        // NROUNDS=2 instance, in_valid held high back-to-back
        nxt; in_valid2 = 1'b1;
        #1 chk("n2_acc", 128'(o2), 128'(e_idle(1'b1)));
        nxt; #1 chk("n2_rnd_rc1", 128'(o2), 128'(e_rnd(4'd1)));
        nxt; #1 chk("n2_final", 128'(o2), 128'(E_FIN));
        nxt; #1 chk("n2_hold", 128'(o2), 128'(E_HOLD));
        nxt; #1 chk("n2_b2b_acc", 128'(o2), 128'(e_idle(1'b1)));
        nxt; in_valid2 = 1'b0;
        #1 chk("n2_rnd2_rc1", 128'(o2), 128'(e_rnd(4'd1)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_decrypt_ctrl.md
AES_DECRYPT_CTRL -- requirements
Module: aes_decrypt_ctrl

Interface
REQ-001 Parameter NROUNDS, default 10, SHALL set the total number of AES rounds; legal range 2..15.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-004 in_valid  input  1  SHALL indicate that ciphertext and key are present on the datapath inputs.
REQ-005 in_ready  output  1  SHALL indicate that the controller accepts a new block.
REQ-006 abort  input  1  SHALL be a synchronous cancel of the operation in flight.
REQ-007 ld_en  output  1  SHALL load the datapath state/key registers with (ciphertext ^ key) and key.
REQ-008 round_en  output  1  SHALL enable one shared inverse-round step (inv sub, inv shift, key add, inv mix; key reg <- inverse key expansion).
REQ-009 final_en  output  1  SHALL enable the final inverse round (no inverse mix columns).
REQ-010 rc  output  4  SHALL be the round-constant index driven to the inverse key expansion.
REQ-011 busy  output  1  SHALL be high in every state except IDLE.
REQ-012 out_valid  output  1  SHALL indicate that the datapath output holds plaintext.
REQ-013 out_ready  input  1  SHALL indicate that the consumer takes the plaintext.

Function
REQ-014 FSM states SHALL be IDLE, ROUND, FINAL, HOLD; encoding free.
REQ-015 IDLE: in_ready=1; in_valid=1 SHALL produce ld_en=1 in the same cycle (combinational), next state ROUND, rc register <- NROUNDS-1.
REQ-016 ROUND: round_en=1, rc=current count; count SHALL decrement each cycle; when count==1, next state FINAL with count <- 0.
REQ-017 FINAL: final_en=1, rc=0 for exactly one cycle; next state HOLD.
REQ-018 HOLD: out_valid=1, held stable with no datapath enables until out_ready=1; then next state IDLE.
REQ-019 Latency: accept at cycle T; ROUND occupies T+1..T+NROUNDS-1 (rc NROUNDS-1 down to 1); FINAL at T+NROUNDS; out_valid first high at T+NROUNDS+1.
REQ-020 in_ready SHALL be 0 outside IDLE; no new block SHALL be accepted in the cycle out_ready completes HOLD.
REQ-021 ld_en, round_en and final_en SHALL be mutually exclusive, and none SHALL be high in HOLD.
REQ-022 Outside ROUND/FINAL, rc SHALL read 0.
REQ-023 abort=1 in ROUND, FINAL or HOLD SHALL force IDLE next cycle, with no out_valid for that block; abort SHALL take priority over out_ready.
REQ-024 abort=1 in IDLE SHALL be ignored; simultaneous abort and in_valid in IDLE SHALL accept the block.
REQ-025 The rc counter SHALL never wrap below 0; an illegal state SHALL return to IDLE.

Reset
REQ-026 While rst=1: state=IDLE, count=0, in_ready=1, busy=0, out_valid=0, round_en=0, final_en=0, rc=0; ld_en=0 irrespective of in_valid.
REQ-027 rst asserted mid-operation SHALL abandon the block immediately (asynchronously) and produce no out_valid for it.

Verification
REQ-028 NROUNDS=10, in_valid pulse at T, out_ready=1 -> ld_en@T, round_en T+1..T+9 with rc 9..1, final_en@T+10 rc=0, out_valid@T+11 only, IDLE@T+12.
REQ-029 Datapath model with FIPS-197 key 000102..0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> plaintext 00112233445566778899aabbccddeeff when out_valid=1.
REQ-030 out_ready held 0 for 5 cycles after out_valid rises -> out_valid stays 1 and all enables stay 0; in_ready=0 throughout.
REQ-031 abort at T+4 -> IDLE at T+5 with in_ready=1; out_valid never asserts; new block at T+5 completes normally.
REQ-032 rst pulsed asynchronously mid-ROUND (rc=6) -> all outputs at reset values before the next edge; no out_valid follows.
REQ-033 Back-to-back in_valid held high -> second ld_en exactly one cycle after out_valid&out_ready handshake; NROUNDS=2 -> one ROUND cycle (rc=1), then FINAL.
